// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP-1 style 8-bit bus datapath; carry/zero flags built only with FLAGS_EN
module sap_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16:0]       cw,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        inst,
  output logic [DATA_W-1:0] out_val,
  output logic              out_valid,
  output logic              halted,
  output logic [DATA_W-1:0] bus,
  output logic              cf,
  output logic              zf,
  output logic              bus_conflict
);

  // control word bit positions
  localparam int CE  = 0;
  localparam int CO  = 1;
  localparam int J   = 2;
  localparam int MI  = 3;
  localparam int RO  = 4;
  localparam int RI  = 5;
  localparam int II  = 6;
  localparam int IO  = 7;
  localparam int AI  = 8;
  localparam int AO  = 9;
  localparam int EO  = 10;
  localparam int SU  = 11;
  localparam int BI  = 12;
  localparam int OI  = 13;
  localparam int FI  = 14;
  localparam int HLT = 16;

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_q;
  logic              out_pulse;
  logic [DATA_W-1:0] ram [DEPTH];

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu_sum;
  logic [2:0]        drv_cnt;
  logic              multi_drv;
  logic              wr_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // cw-driven writes only happen when running and not halted
  assign wr_en = ~prog_mode & ~halted;

  // ALU: add, or subtract as A + ~B + 1 so carry means "no borrow"
  always_comb begin
    b_op    = cw[SU] ? ~b_reg : b_reg;
    alu_sum = {1'b0, a_reg} + {1'b0, b_op} + {{DATA_W{1'b0}}, cw[SU]};
  end

  // bus mux with fixed driver priority; narrow sources zero-extended
  always_comb begin
    bus = '0;
    if (cw[CO])      bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    else if (cw[RO]) bus = ram[mar];
    else if (cw[IO]) bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
    else if (cw[AO]) bus = a_reg;
    else if (cw[EO]) bus = alu_sum[DATA_W-1:0];
  end

  // count active bus drivers to detect contention
  always_comb begin
    drv_cnt   = 3'(cw[CO]) + 3'(cw[RO]) + 3'(cw[IO]) + 3'(cw[AO]) + 3'(cw[EO]);
    multi_drv = (drv_cnt > 3'd1);
  end

  // RAM write port select: program port in prog_mode, else RI at the old MAR; dropped under reset
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mar;
    ram_wdata = bus;
    if (!rst) begin
      if (prog_mode) begin
        ram_we    = prog_we;
        ram_waddr = prog_addr;
        ram_wdata = prog_data;
      end else if (wr_en && cw[RI]) begin
        ram_we = 1'b1;
      end
    end
  end

  // RAM storage, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // architectural registers, halt and conflict state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      mar          <= '0;
      ir           <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      out_q        <= '0;
      out_pulse    <= 1'b0;
      halted       <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      out_pulse <= 1'b0;
      if (multi_drv) bus_conflict <= 1'b1;
      if (wr_en) begin
        if (cw[MI]) mar   <= bus[ADDR_W-1:0];
        if (cw[II]) ir    <= bus;
        if (cw[AI]) a_reg <= bus;
        if (cw[BI]) b_reg <= bus;
        if (cw[J])       pc <= bus[ADDR_W-1:0];
        else if (cw[CE]) pc <= pc + ADDR_W'(1);
        if (cw[OI]) begin
          out_q     <= bus;
          out_pulse <= 1'b1;
        end
        if (cw[HLT]) halted <= 1'b1;
      end
    end
  end

`ifdef FLAGS_EN
  // flags capture ALU carry-out and zero on FI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cf <= 1'b0;
      zf <= 1'b0;
    end else if (wr_en && cw[FI]) begin
      cf <= alu_sum[DATA_W];
      zf <= (alu_sum[DATA_W-1:0] == '0);
    end
  end

  logic unused_rsv;
  assign unused_rsv = cw[15];
`else
  assign cf = 1'b0;
  assign zf = 1'b0;

  logic unused_flags;
  assign unused_flags = ^{cw[15], cw[FI], alu_sum[DATA_W]};
`endif

  assign inst      = ir[DATA_W-1:DATA_W-4];
  assign out_val   = out_q;
  assign out_valid = out_pulse & ~halted & ~prog_mode;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - directed and randomized checks of sap_datapath against a reference model
module tb_sap_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] cw;
  logic        prog_mode;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  inst;
  logic [7:0]  out_val;
  logic        out_valid;
  logic        halted;
  logic [7:0]  bus;
  logic        cf;
  logic        zf;
  logic        bus_conflict;

  int checks   = 0;
  int failures = 0;

  localparam logic [16:0] C_CE  = 17'h00001;
  localparam logic [16:0] C_CO  = 17'h00002;
  localparam logic [16:0] C_J   = 17'h00004;
  localparam logic [16:0] C_MI  = 17'h00008;
  localparam logic [16:0] C_RO  = 17'h00010;
  localparam logic [16:0] C_II  = 17'h00040;
  localparam logic [16:0] C_IO  = 17'h00080;
  localparam logic [16:0] C_AI  = 17'h00100;
  localparam logic [16:0] C_AO  = 17'h00200;
  localparam logic [16:0] C_EO  = 17'h00400;
  localparam logic [16:0] C_SU  = 17'h00800;
  localparam logic [16:0] C_BI  = 17'h01000;
  localparam logic [16:0] C_OI  = 17'h02000;
  localparam logic [16:0] C_FI  = 17'h04000;
  localparam logic [16:0] C_HLT = 17'h10000;

`ifdef FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .cw(cw), .prog_mode(prog_mode), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .inst(inst), .out_val(out_val),
    .out_valid(out_valid), .halted(halted), .bus(bus), .cf(cf), .zf(zf),
    .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic       m_ov, m_halt, m_conf, m_cf, m_zf;
  logic [7:0] m_ram [16];

  function automatic logic [7:0] model_alu(input logic sub);
    return sub ? m_a - m_b : m_a + m_b;
  endfunction

  function automatic logic [7:0] model_bus(input logic [16:0] c);
    if (c[1]) return {4'h0, m_pc};
    if (c[4]) return m_ram[m_mar];
    if (c[7]) return {4'h0, m_ir[3:0]};
    if (c[9]) return m_a;
    if (c[10]) return model_alu(c[11]);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
    m_ov = 0; m_halt = 0; m_conf = 0; m_cf = 0; m_zf = 0;
  endtask

  task automatic model_clock(input logic [16:0] c, input logic pm, input logic we,
                             input logic [3:0] pa, input logic [7:0] pd);
    logic [7:0] bv;
    logic [7:0] alu_v;
    int nd;
    bv    = model_bus(c);
    alu_v = model_alu(c[11]);
    nd = int'(c[1]) + int'(c[4]) + int'(c[7]) + int'(c[9]) + int'(c[10]);
    if (nd > 1) m_conf = 1'b1;
    m_ov = 1'b0;
    if (pm) begin
      if (we) m_ram[pa] = pd;
    end else if (!m_halt) begin
      if (c[5]) m_ram[m_mar] = bv;
`ifdef FLAGS_EN
      if (c[14]) begin
        m_cf = c[11] ? (m_a >= m_b) : ((int'(m_a) + int'(m_b)) > 255);
        m_zf = (alu_v == 8'h00);
      end
`endif
      if (c[3]) m_mar = bv[3:0];
      if (c[6]) m_ir = bv;
      if (c[8]) m_a = bv;
      if (c[12]) m_b = bv;
      if (c[2]) m_pc = bv[3:0];
      else if (c[0]) m_pc = m_pc + 4'd1;
      if (c[13]) begin m_out = bv; m_ov = 1'b1; end
      if (c[16]) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [16:0] c);
    cw = c;
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    cw = 17'h0; prog_mode = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0; prog_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cw = 17'h0; prog_mode = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({inst, out_val, out_valid, halted} !== 14'h0) begin
      failures++; $display("FAIL reset_regs got=%h want=0", {inst, out_val, out_valid, halted});
    end
    checks++;
    if ({bus, cf, zf, bus_conflict} !== 11'h0) begin
      failures++; $display("FAIL reset_bus_flags got=%h want=0", {bus, cf, zf, bus_conflict});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    prog_write(4'h0, 8'h1E);
    drive(C_CO | C_MI);
    checks++;
    if (bus !== 8'h00) begin failures++; $display("FAIL fetch_pc_bus got=%h want=00", bus); end
    tick();
    drive(C_RO);
    checks++;
    if (bus !== 8'h1E) begin failures++; $display("FAIL fetch_mar_read got=%h want=1e", bus); end
    drive(C_RO | C_II | C_CE);
    tick();
    checks++;
    if (inst !== 4'h1) begin failures++; $display("FAIL fetch_inst got=%h want=1", inst); end
    drive(C_CO);
    checks++;
    if (bus !== 8'h01) begin failures++; $display("FAIL fetch_pc_inc got=%h want=01", bus); end
  endtask

  task automatic test_add();
    drive(C_IO | C_MI);
    checks++;
    if (bus !== 8'h0E) begin failures++; $display("FAIL add_io_bus got=%h want=0e", bus); end
    tick();
    prog_write(4'hE, 8'hF0); drive(C_RO | C_AI); tick();
    prog_write(4'hE, 8'h20); drive(C_RO | C_BI); tick();
    drive(C_EO | C_AI | C_FI);
    checks++;
    if (bus !== 8'h10) begin failures++; $display("FAIL add_alu_bus got=%h want=10", bus); end
    tick();
    drive(C_AO);
    checks++;
    if ({bus, cf, zf} !== {8'h10, FL, 1'b0}) begin
      failures++; $display("FAIL add_result got=%h want=%h", {bus, cf, zf}, {8'h10, FL, 1'b0});
    end
    prog_write(4'hE, 8'h05); drive(C_RO | C_AI); tick();
    drive(C_RO | C_BI); tick();
    drive(C_EO | C_SU | C_AI | C_FI);
    tick();
    drive(C_AO);
    checks++;
    if ({bus, cf, zf} !== {8'h00, FL, FL}) begin
      failures++; $display("FAIL sub_result got=%h want=%h", {bus, cf, zf}, {8'h00, FL, FL});
    end
  endtask

  task automatic test_output();
    prog_write(4'hE, 8'h2A); drive(C_RO | C_AI); tick();
    drive(C_AO | C_OI);
    tick();
    checks++;
    if ({out_val, out_valid} !== {8'h2A, 1'b1}) begin
      failures++; $display("FAIL out_load got=%h want=%h", {out_val, out_valid}, {8'h2A, 1'b1});
    end
    drive(17'h0);
    tick();
    checks++;
    if ({out_val, out_valid} !== {8'h2A, 1'b0}) begin
      failures++; $display("FAIL out_pulse_end got=%h want=%h", {out_val, out_valid}, {8'h2A, 1'b0});
    end
  endtask

  task automatic test_pc_jump();
    prog_write(4'hE, 8'h0F); drive(C_RO | C_J); tick();
    drive(C_CO);
    checks++;
    if (bus !== 8'h0F) begin failures++; $display("FAIL pc_jump15 got=%h want=0f", bus); end
    drive(C_CE); tick();
    drive(C_CO);
    checks++;
    if (bus !== 8'h00) begin failures++; $display("FAIL pc_wrap got=%h want=00", bus); end
    prog_write(4'hE, 8'h47); drive(C_RO | C_II); tick();
    checks++;
    if (inst !== 4'h4) begin failures++; $display("FAIL ir_load got=%h want=4", inst); end
    drive(C_IO | C_J | C_CE);
    tick();
    drive(C_CO);
    checks++;
    if (bus !== 8'h07) begin failures++; $display("FAIL jump_priority got=%h want=07", bus); end
  endtask

  task automatic test_halt();
    prog_write(4'hE, 8'h55); drive(C_RO | C_AI); tick();
    drive(C_HLT); tick();
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%b want=1", halted); end
    drive(C_AO | C_OI);
    checks++;
    if (bus !== 8'h55) begin failures++; $display("FAIL halt_bus_live got=%h want=55", bus); end
    tick();
    checks++;
    if ({out_val, out_valid} !== {8'h2A, 1'b0}) begin
      failures++; $display("FAIL halt_out_frozen got=%h want=%h", {out_val, out_valid}, {8'h2A, 1'b0});
    end
    drive(C_CE); tick();
    drive(C_CO);
    checks++;
    if (bus !== 8'h07) begin failures++; $display("FAIL halt_pc_frozen got=%h want=07", bus); end
    drive(17'h0);
    rst = 1'b1;
    #1;
    checks++;
    if ({inst, out_val, out_valid, halted, bus, cf, zf, bus_conflict} !== 25'h0) begin
      failures++; $display("FAIL halt_reset got=%h want=0", {inst, out_val, out_valid, halted, bus, cf, zf, bus_conflict});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_conflict();
    drive(C_CE); tick();
    drive(C_CO | C_AO);
    checks++;
    if (bus !== 8'h01) begin failures++; $display("FAIL conflict_priority got=%h want=01", bus); end
    tick();
    checks++;
    if (bus_conflict !== 1'b1) begin failures++; $display("FAIL conflict_set got=%b want=1", bus_conflict); end
    drive(17'h0); tick();
    checks++;
    if (bus_conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky got=%b want=1", bus_conflict); end
    drive(C_CO | C_MI);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus_conflict !== 1'b0) begin failures++; $display("FAIL conflict_reset got=%b want=0", bus_conflict); end
    @(negedge clk);
    rst = 1'b0;
    drive(C_RO);
    checks++;
    if (bus !== 8'h1E) begin failures++; $display("FAIL ram_survives_reset got=%h want=1e", bus); end
  endtask

  task automatic test_random();
    logic [16:0] c;
    logic [7:0]  exp_bus;
    logic [15:0] exp_st;
    logic        pm, we;
    logic [3:0]  pa;
    logic [7:0]  pd;
    int drv_tab [5] = '{1, 4, 7, 9, 10};
    int k;
    drive(17'h0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      pd = 8'($urandom);
      prog_write(4'(i), pd);
      m_ram[i] = pd;
    end
    for (int n = 0; n < 400; n++) begin
      pm = ($urandom_range(0, 9) == 0);
      we = 1'($urandom);
      pa = 4'($urandom);
      pd = 8'($urandom);
      c  = 17'h0;
      if (!pm) begin
        c = 17'($urandom) & 17'h0F96D;
        k = int'($urandom_range(0, 5));
        if (k < 5) c[drv_tab[k]] = 1'b1;
        if ($urandom_range(0, 15) == 0) c[drv_tab[$urandom_range(0, 4)]] = 1'b1;
      end
      prog_mode = pm; prog_we = we; prog_addr = pa; prog_data = pd;
      drive(c);
      exp_bus = model_bus(c);
      checks++;
      if (bus !== exp_bus) begin
        failures++; $display("FAIL rand_bus step=%0d cw=%h got=%h want=%h", n, c, bus, exp_bus);
      end
      @(posedge clk);
      model_clock(c, pm, we, pa, pd);
      @(negedge clk);
      exp_st = {m_ir[7:4], m_out, m_ov & ~m_halt, m_halt, m_cf, m_zf};
      checks++;
      if ({inst, out_val, out_valid, halted, cf, zf} !== exp_st || bus_conflict !== m_conf) begin
        failures++;
        $display("FAIL rand_state step=%0d cw=%h got=%h/%b want=%h/%b", n, c,
                 {inst, out_val, out_valid, halted, cf, zf}, bus_conflict, exp_st, m_conf);
      end
    end
    prog_mode = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add();
    test_output();
    test_pc_jump();
    test_halt();
    test_conflict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Datapath that consumes the 17-bit control word produced by the CPU control unit and executes it on a shared 8-bit bus.
- Contains the PC, MAR, 16x8 RAM, IR, A, B, ALU, flags and output register.
- Returns the opcode nibble to the control unit, which closes the fetch/execute loop.
- A program-load port fills the RAM before a run.

Parameters:
- DATA_W, 8, bus/register width (only 8 supported).
- ADDR_W, 4, PC/MAR/operand width; RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high; clock clk.
- cw  in  17  control word, held stable for the whole cycle.
- prog_mode  in  1  1 = freeze datapath and enable the program port.
- prog_we  in  1  RAM write strobe; honoured only when prog_mode=1.
- prog_addr  in  4  RAM write address.
- prog_data  in  8  RAM write data.
- inst  out  4  IR[7:4], opcode to the control unit.
- out_val  out  8  output register.
- out_valid  out  1  one-cycle pulse on each OI load.
- halted  out  1  sticky halt.
- bus  out  8  current bus value (observation only).
- cf  out  1  carry flag.
- zf  out  1  zero flag.
- bus_conflict  out  1  sticky multi-driver error.

Behaviour:
- Control word bits:
  - 0 CE = PC increment
  - 1 CO = PC out
  - 2 J = PC load
  - 3 MI = MAR in
  - 4 RO = RAM out
  - 5 RI = RAM in
  - 6 II = IR in
  - 7 IO = IR[3:0] out
  - 8 AI, 9 AO, 10 EO = ALU out, 11 SU = subtract, 12 BI, 13 OI, 14 FI = flags in
  - 15 reserved, ignored
  - 16 HLT
- Bus is combinational from the current cw.
  - Driver priority: CO > RO > IO > AO > EO.
  - 4-bit sources are zero-extended to 8 bits.
  - No driver -> bus = 8'h00.
- bus_conflict sets at a posedge where two or more driver bits are 1. It is cleared only by rst.
- All loads happen at posedge clk and sample the bus value of that cycle. Loads: MAR<=bus[3:0], IR, A, B, OUT, RAM[MAR] (RI), PC<=bus[3:0] (J).
- PC update:
  - CE: PC+1 mod 16 (15 -> 0).
  - J and CE in the same cycle: J wins.
- ALU (combinational):
  - SU=0: A+B. SU=1: A+(~B)+1.
  - 9-bit result; EO drives the low 8 bits.
  - FI latches cf = bit 8 and zf = (low 8 == 0).
- RO and RI in the same cycle: RAM[MAR] is rewritten with its own value (no change).
- MI and RO/RI in the same cycle: the RAM access uses the old MAR.
- Halt:
  - cw[16]=1 at a posedge sets halted=1.
  - While halted, every register, RAM and flag write is inhibited; bus and ALU keep evaluating.
  - Only rst clears halted.
- prog_mode=1:
  - All cw-driven writes are inhibited, including HLT.
  - prog_we writes RAM[prog_addr] <= prog_data at posedge.
  - prog_mode is independent of halted, so the RAM can be reloaded while halted.
- Reset values: PC, MAR, IR, A, B, out_val, cf, zf = 0; halted = 0; bus_conflict = 0; out_valid = 0. RAM contents are not reset.
- Reset mid-instruction aborts immediately. Registers take reset values asynchronously. A RAM write in flight at the rst edge is dropped.
- out_valid is 1 for exactly the cycle after an accepted OI load. It is 0 otherwise, and 0 while halted or in prog_mode.
- inst = IR[7:4] combinationally.

Optional Feature:
- Macro FLAGS_EN.
  - Defined: cf/zf register as above and are cleared by rst.
  - Not defined: no flag flops; cf=zf=0 constantly and FI is ignored.
- All other behaviour is identical either way.

Test Plan:
- Fetch sequencing:
  - Load RAM[0]=8'h1E via prog port, release prog_mode.
  - Apply cw CO|MI, then RO|II|CE.
  - Expect MAR=0 then inst=4'h1 and PC=1.
- Add:
  - A=8'hF0, B=8'h20, cw EO|AI|FI.
  - Expect A=8'h10, cf=1, zf=0.
  - Repeat with SU set, A=8'h05, B=8'h05: expect A=0, zf=1, cf=1.
- Output:
  - A=8'h2A, cw AO|OI.
  - Expect out_val=8'h2A, out_valid high exactly one cycle.
- PC wrap and jump priority:
  - PC=15, CE: expect PC=0.
  - IR=8'h47, cw IO|J|CE: expect PC=7.
- Halt freeze:
  - cw HLT, then AO|OI and CE cycles.
  - Expect halted=1, PC/out_val unchanged, out_valid=0.
  - Assert rst: all outputs return to 0.
- Bus conflict and reset:
  - cw CO|AO: expect bus=PC (priority) and bus_conflict=1 sticky.
  - rst mid-sequence clears it.
  - RAM[0] still reads 8'h1E.
